// File: rtl/lgen_pkg.sv
// Shared XGMII character set, receive FSM state type and default frame-field offsets
// for the load generator transmit and receive paths.
package lgen_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_PRE   = 8'h55;
  localparam logic [7:0] XGMII_SFD   = 8'hD5;

  localparam int OFS_SEQ_DEF = 42;
  localparam int MIN_LEN_DEF = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } rx_state_e;

  // Lane-0 start followed by preamble and SFD, the only supported start alignment.
  function automatic logic is_start_word(input logic [63:0] d, input logic [7:0] c);
    return (c == 8'h01) && (d[7:0] == XGMII_START) &&
           (d[55:8] == {6{XGMII_PRE}}) && (d[63:56] == XGMII_SFD);
  endfunction

endpackage

// File: rtl/lgen_xgmii_term_find.sv
// Lowest-set-lane encoder over an XGMII control mask: reports whether that lane
// carries a terminate character or some other control character.
module lgen_xgmii_term_find
  import lgen_pkg::*;
(
  input  logic [63:0] rxd_i,
  input  logic [7:0]  rxc_i,
  output logic        term_found_o,
  output logic [2:0]  term_lane_o,
  output logic        other_ctrl_o
);

  logic [7:0] low_byte;

  always_comb begin
    term_lane_o = 3'd0;
    low_byte    = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (rxc_i[i]) begin
        term_lane_o = 3'(i);
        low_byte    = rxd_i[8*i +: 8];
      end
    end
    term_found_o = (rxc_i != 8'h00) && (low_byte == XGMII_TERM);
    other_ctrl_o = (rxc_i != 8'h00) && (low_byte != XGMII_TERM);
  end

endmodule

// File: rtl/lgen_rx_checker.sv
// Receive-side frame checker: delimits XGMII frames, extracts sequence number and
// transmit timestamp, and keeps sequence/latency/error statistics.
module lgen_rx_checker
  import lgen_pkg::*;
#(
  parameter int OFS_SEQ = OFS_SEQ_DEF,
  parameter int MIN_LEN = MIN_LEN_DEF
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [63:0] ts_now,
  input  logic        stat_clr,
  output logic        frame_done,
  output logic [31:0] frame_seq,
  output logic [31:0] frame_lat,
  output logic [15:0] frame_len,
  output logic [31:0] cnt_frames,
  output logic [47:0] cnt_bytes,
  output logic [31:0] cnt_seq_err,
  output logic [31:0] cnt_runt,
  output logic [31:0] cnt_ctrl_err,
  output logic [31:0] lat_min,
  output logic [31:0] lat_max
);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [31:0] sat_lat(input logic [63:0] d);
    return (d[63:32] == 32'd0) ? d[31:0] : 32'hFFFF_FFFF;
  endfunction

  // ---- stage p0: XGMII input register; ts_now travels with the word it was sampled on
  logic [63:0] rxd_p0_q;
  logic [7:0]  rxc_p0_q;
  logic [63:0] tsnow_p0_q;

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) rxc_p0_q <= 8'hFF;
    else            rxc_p0_q <= xgmii_rxc;
  end

  always_ff @(posedge clk156) begin
    rxd_p0_q   <= xgmii_rxd;
    tsnow_p0_q <= ts_now;
  end

  logic       term_found;
  logic [2:0] term_lane;
  logic       other_ctrl;

  lgen_xgmii_term_find u_term_find (
    .rxd_i        (rxd_p0_q),
    .rxc_i        (rxc_p0_q),
    .term_found_o (term_found),
    .term_lane_o  (term_lane),
    .other_ctrl_o (other_ctrl)
  );

  rx_state_e   state_q, state_d;
  logic [15:0] bytes_q, bytes_d;
  logic [31:0] seq_cap_q, seq_cap_d;
  logic [63:0] ts_cap_q, ts_cap_d;
  logic        start_w, lane4_start;
  logic        end_d, acc_d, runt_d, cerr_d;
  logic [15:0] len_d;
  logic [31:0] lat_d;

  assign start_w     = is_start_word(rxd_p0_q, rxc_p0_q);
  assign lane4_start = rxc_p0_q[4] && (rxd_p0_q[39:32] == XGMII_START);

  always_comb begin
    int k;
    state_d   = state_q;
    bytes_d   = bytes_q;
    seq_cap_d = seq_cap_q;
    ts_cap_d  = ts_cap_q;
    end_d     = 1'b0;
    cerr_d    = 1'b0;
    k         = 0;
    len_d     = sat_add16(bytes_q, {13'd0, term_lane});
    case (state_q)
      ST_IDLE: begin
        if (start_w) begin
          state_d = ST_DATA;
          bytes_d = 16'd0;
        end else if (lane4_start) begin
          cerr_d = 1'b1;
        end
      end
      default: begin
        // bytes_q is the frame offset of lane 0 of the current word
        if (!start_w) begin
          for (int l = 0; l < 8; l++) begin
            if (!rxc_p0_q[l]) begin
              k = int'(bytes_q) + l;
              if (k >= OFS_SEQ && k < OFS_SEQ + 4)
                seq_cap_d[8*(OFS_SEQ+3-k) +: 8] = rxd_p0_q[8*l +: 8];
              else if (k >= OFS_SEQ + 4 && k < OFS_SEQ + 12)
                ts_cap_d[8*(OFS_SEQ+11-k) +: 8] = rxd_p0_q[8*l +: 8];
            end
          end
        end
        if (start_w) begin
          cerr_d  = 1'b1;
          bytes_d = 16'd0;
        end else if (term_found) begin
          end_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (other_ctrl) begin
          cerr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          bytes_d = sat_add16(bytes_q, 16'd8);
        end
      end
    endcase
    acc_d  = end_d && (len_d >= 16'(MIN_LEN));
    runt_d = end_d && !acc_d;
    lat_d  = sat_lat(tsnow_p0_q - ts_cap_d);
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      bytes_q <= 16'd0;
    end else begin
      state_q <= state_d;
      bytes_q <= bytes_d;
    end
  end

  always_ff @(posedge clk156) begin
    seq_cap_q <= seq_cap_d;
    ts_cap_q  <= ts_cap_d;
  end

  // ---- stage p1: per-frame result
  logic        vld_p1_q, runt_p1_q, cerr_p1_q;
  logic [15:0] len_p1_q;
  logic [31:0] seq_p1_q, lat_p1_q;

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p1_q  <= 1'b0;
      runt_p1_q <= 1'b0;
      cerr_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= acc_d;
      runt_p1_q <= runt_d;
      cerr_p1_q <= cerr_d;
    end
  end

  always_ff @(posedge clk156) begin
    len_p1_q <= len_d;
    seq_p1_q <= seq_cap_d;
    lat_p1_q <= lat_d;
  end

  // ---- stage p2: statistics and frame outputs; a clear overrides a completing frame
  logic        done_q, seq_vld_q;
  logic [31:0] exp_seq_q, frame_seq_q, frame_lat_q;
  logic [15:0] frame_len_q;
  logic [31:0] cnt_frames_q, cnt_seq_err_q, cnt_runt_q, cnt_ctrl_err_q;
  logic [47:0] cnt_bytes_q;
  logic [31:0] lat_min_q, lat_max_q;

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_q         <= 1'b0;
      seq_vld_q      <= 1'b0;
      exp_seq_q      <= 32'd0;
      frame_seq_q    <= 32'd0;
      frame_lat_q    <= 32'd0;
      frame_len_q    <= 16'd0;
      cnt_frames_q   <= 32'd0;
      cnt_bytes_q    <= 48'd0;
      cnt_seq_err_q  <= 32'd0;
      cnt_runt_q     <= 32'd0;
      cnt_ctrl_err_q <= 32'd0;
      lat_min_q      <= 32'hFFFF_FFFF;
      lat_max_q      <= 32'd0;
    end else begin
      done_q <= 1'b0;
      if (stat_clr) begin
        seq_vld_q      <= 1'b0;
        cnt_frames_q   <= 32'd0;
        cnt_bytes_q    <= 48'd0;
        cnt_seq_err_q  <= 32'd0;
        cnt_runt_q     <= 32'd0;
        cnt_ctrl_err_q <= 32'd0;
        lat_min_q      <= 32'hFFFF_FFFF;
        lat_max_q      <= 32'd0;
      end else begin
        if (runt_p1_q) cnt_runt_q <= cnt_runt_q + 32'd1;
        if (cerr_p1_q) cnt_ctrl_err_q <= cnt_ctrl_err_q + 32'd1;
        if (vld_p1_q) begin
          done_q       <= 1'b1;
          frame_seq_q  <= seq_p1_q;
          frame_lat_q  <= lat_p1_q;
          frame_len_q  <= len_p1_q;
          cnt_frames_q <= cnt_frames_q + 32'd1;
          cnt_bytes_q  <= cnt_bytes_q + {32'd0, len_p1_q};
          if (seq_vld_q && (seq_p1_q != exp_seq_q)) cnt_seq_err_q <= cnt_seq_err_q + 32'd1;
          exp_seq_q <= seq_p1_q + 32'd1;
          seq_vld_q <= 1'b1;
          if (lat_p1_q < lat_min_q) lat_min_q <= lat_p1_q;
          if (lat_p1_q > lat_max_q) lat_max_q <= lat_p1_q;
        end
      end
    end
  end

  assign frame_done   = done_q;
  assign frame_seq    = frame_seq_q;
  assign frame_lat    = frame_lat_q;
  assign frame_len    = frame_len_q;
  assign cnt_frames   = cnt_frames_q;
  assign cnt_bytes    = cnt_bytes_q;
  assign cnt_seq_err  = cnt_seq_err_q;
  assign cnt_runt     = cnt_runt_q;
  assign cnt_ctrl_err = cnt_ctrl_err_q;
  assign lat_min      = lat_min_q;
  assign lat_max      = lat_max_q;

endmodule

// File: tb/tb_lgen_rx_checker.sv
// Directed bench for lgen_rx_checker: builds XGMII frames with embedded sequence
// number and timestamp and checks statistics against hand-computed values.
module tb_lgen_rx_checker;
  import lgen_pkg::*;

  localparam int OFS = 42;

  logic        clk156 = 1'b0;
  logic        sys_rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [63:0] ts_now;
  logic        stat_clr;
  logic        frame_done;
  logic [31:0] frame_seq, frame_lat;
  logic [15:0] frame_len;
  logic [31:0] cnt_frames;
  logic [47:0] cnt_bytes;
  logic [31:0] cnt_seq_err, cnt_runt, cnt_ctrl_err, lat_min, lat_max;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  lgen_rx_checker dut (
    .clk156       (clk156),
    .sys_rst_n    (sys_rst_n),
    .xgmii_rxd    (xgmii_rxd),
    .xgmii_rxc    (xgmii_rxc),
    .ts_now       (ts_now),
    .stat_clr     (stat_clr),
    .frame_done   (frame_done),
    .frame_seq    (frame_seq),
    .frame_lat    (frame_lat),
    .frame_len    (frame_len),
    .cnt_frames   (cnt_frames),
    .cnt_bytes    (cnt_bytes),
    .cnt_seq_err  (cnt_seq_err),
    .cnt_runt     (cnt_runt),
    .cnt_ctrl_err (cnt_ctrl_err),
    .lat_min      (lat_min),
    .lat_max      (lat_max)
  );

  always #5 clk156 = ~clk156;

  always @(negedge clk156) if (frame_done === 1'b1) done_cnt++;

  task automatic put(input logic [7:0] c, input logic [63:0] d);
    xgmii_rxc = c;
    xgmii_rxd = d;
    ts_now    = ts_now + 64'd1;
    @(posedge clk156);
    #1;
  endtask

  task automatic idle();
    put(8'hFF, {8{XGMII_IDLE}});
  endtask

  task automatic preamble();
    put(8'h01, {XGMII_SFD, {6{XGMII_PRE}}, XGMII_START});
  endtask

  // Ends right after the terminate word; off is the intended latency vs ts_now at that word.
  task automatic send_frame(input int len, input logic [31:0] seq, input longint off);
    logic [7:0]  fb [0:127];
    logic [63:0] ts, w, t0;
    logic [7:0]  c;
    int nfull, lt;
    nfull = len / 8;
    lt    = len % 8;
    t0    = ts_now;
    ts    = t0 + 64'(2 + nfull) - 64'(off);
    for (int k = 0; k < 128; k++) fb[k] = 8'(k);
    for (int i = 0; i < 4; i++) fb[OFS+i] = seq[8*(3-i) +: 8];
    for (int i = 0; i < 8; i++) fb[OFS+4+i] = ts[8*(7-i) +: 8];
    preamble();
    for (int wi = 0; wi < nfull; wi++) begin
      for (int l = 0; l < 8; l++) w[8*l +: 8] = fb[8*wi+l];
      put(8'h00, w);
    end
    c = 8'h00;
    for (int l = 0; l < 8; l++) begin
      if (l < lt) w[8*l +: 8] = fb[8*nfull+l];
      else if (l == lt) begin w[8*l +: 8] = XGMII_TERM; c[l] = 1'b1; end
      else begin w[8*l +: 8] = XGMII_IDLE; c[l] = 1'b1; end
    end
    put(c, w);
  endtask

  task automatic test_reset();
    n_tests++; if (cnt_frames !== 32'd0) begin n_fail++; $display("FAIL reset_frames: got %0d want 0", cnt_frames); end
    n_tests++; if (cnt_bytes !== 48'd0) begin n_fail++; $display("FAIL reset_bytes: got %0d want 0", cnt_bytes); end
    n_tests++; if (lat_min !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_lat_min: got %0h want ffffffff", lat_min); end
    n_tests++; if (lat_max !== 32'd0) begin n_fail++; $display("FAIL reset_lat_max: got %0h want 0", lat_max); end
    n_tests++; if (frame_done !== 1'b0 || frame_seq !== 32'd0) begin n_fail++; $display("FAIL reset_frame: got done=%b seq=%0d want 0/0", frame_done, frame_seq); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      send_frame(64, 32'(100 + i), 500);
      idle();
    end
    idle(); idle(); idle();
    n_tests++; if (cnt_frames !== 32'd10) begin n_fail++; $display("FAIL b2b_frames: got %0d want 10", cnt_frames); end
    n_tests++; if (cnt_bytes !== 48'd640) begin n_fail++; $display("FAIL b2b_bytes: got %0d want 640", cnt_bytes); end
    n_tests++; if (cnt_seq_err !== 32'd0) begin n_fail++; $display("FAIL b2b_seq_err: got %0d want 0", cnt_seq_err); end
    n_tests++; if (frame_lat !== 32'd500) begin n_fail++; $display("FAIL b2b_lat: got %0d want 500", frame_lat); end
    n_tests++; if (lat_min !== 32'd500 || lat_max !== 32'd500) begin n_fail++; $display("FAIL b2b_minmax: got %0d/%0d want 500/500", lat_min, lat_max); end
    n_tests++; if (frame_seq !== 32'd109) begin n_fail++; $display("FAIL b2b_seq: got %0d want 109", frame_seq); end
    n_tests++; if (done_cnt - d0 !== 10) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 10", done_cnt - d0); end
  endtask

  task automatic test_done_timing();
    send_frame(64, 32'd110, 500);
    idle();
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b want 0", frame_done); end
    idle();
    n_tests++; if (frame_done !== 1'b1 || frame_seq !== 32'd110) begin n_fail++; $display("FAIL done_at_2: got done=%b seq=%0d want 1/110", frame_done, frame_seq); end
    idle();
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", frame_done); end
  endtask

  task automatic test_term_lanes();
    for (int i = 0; i < 8; i++) begin
      send_frame(64 + i, 32'(111 + i), 500);
      idle(); idle(); idle();
      n_tests++; if (frame_len !== 16'(64 + i)) begin n_fail++; $display("FAIL term_len_L%0d: got %0d want %0d", i, frame_len, 64 + i); end
    end
    n_tests++; if (cnt_bytes !== 48'd1244) begin n_fail++; $display("FAIL term_bytes: got %0d want 1244", cnt_bytes); end
    n_tests++; if (cnt_frames !== 32'd19 || cnt_seq_err !== 32'd0) begin n_fail++; $display("FAIL term_frames: got %0d/%0d want 19/0", cnt_frames, cnt_seq_err); end
  endtask

  task automatic test_seq_gap();
    stat_clr = 1'b1;
    idle();
    stat_clr = 1'b0;
    idle();
    n_tests++; if (cnt_frames !== 32'd0 || cnt_bytes !== 48'd0 || lat_min !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL clr_idle: got %0d/%0d/%0h want 0/0/ffffffff", cnt_frames, cnt_bytes, lat_min); end
    send_frame(64, 32'd5, 500); idle();
    send_frame(64, 32'd6, 500); idle();
    send_frame(64, 32'd8, 500); idle();
    send_frame(64, 32'd9, 500); idle();
    idle(); idle();
    n_tests++; if (cnt_seq_err !== 32'd1) begin n_fail++; $display("FAIL gap_seq_err: got %0d want 1", cnt_seq_err); end
    n_tests++; if (frame_seq !== 32'd9) begin n_fail++; $display("FAIL gap_seq: got %0d want 9", frame_seq); end
    n_tests++; if (cnt_frames !== 32'd4) begin n_fail++; $display("FAIL gap_frames: got %0d want 4", cnt_frames); end
  endtask

  task automatic test_errors();
    logic [63:0] w;
    send_frame(60, 32'd10, 500);
    idle(); idle(); idle();
    n_tests++; if (cnt_runt !== 32'd1 || cnt_frames !== 32'd4) begin n_fail++; $display("FAIL runt: got runt=%0d frames=%0d want 1/4", cnt_runt, cnt_frames); end
    preamble();
    put(8'h00, 64'h0123_4567_89AB_CDEF);
    put(8'h00, 64'h0);
    put(8'h00, 64'h0);
    w = 64'h0;
    w[31:24] = XGMII_ERR;
    put(8'h08, w);
    idle(); idle(); idle();
    n_tests++; if (cnt_ctrl_err !== 32'd1 || cnt_frames !== 32'd4) begin n_fail++; $display("FAIL ctrl_fe: got cerr=%0d frames=%0d want 1/4", cnt_ctrl_err, cnt_frames); end
    preamble();
    put(8'h00, 64'h0);
    put(8'h00, 64'h0);
    send_frame(64, 32'd10, 500);
    idle(); idle(); idle();
    n_tests++; if (cnt_ctrl_err !== 32'd2) begin n_fail++; $display("FAIL ctrl_restart: got %0d want 2", cnt_ctrl_err); end
    n_tests++; if (cnt_frames !== 32'd5 || frame_seq !== 32'd10) begin n_fail++; $display("FAIL restart_frame: got frames=%0d seq=%0d want 5/10", cnt_frames, frame_seq); end
    n_tests++; if (cnt_seq_err !== 32'd1 || cnt_runt !== 32'd1) begin n_fail++; $display("FAIL err_side: got seq_err=%0d runt=%0d want 1/1", cnt_seq_err, cnt_runt); end
  endtask

  task automatic test_neg_latency();
    send_frame(64, 32'd11, -10);
    idle(); idle(); idle();
    n_tests++; if (frame_lat !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL neg_lat: got %0h want ffffffff", frame_lat); end
    n_tests++; if (lat_max !== 32'hFFFF_FFFF || lat_min !== 32'd500) begin n_fail++; $display("FAIL neg_minmax: got %0h/%0h want 1f4/ffffffff", lat_min, lat_max); end
  endtask

  task automatic test_clr_and_reset();
    send_frame(64, 32'd12, 500);
    stat_clr = 1'b1;
    idle(); idle(); idle();
    stat_clr = 1'b0;
    idle();
    n_tests++; if (cnt_frames !== 32'd0 || cnt_bytes !== 48'd0 || cnt_seq_err !== 32'd0) begin n_fail++; $display("FAIL clr_counts: got %0d/%0d/%0d want 0/0/0", cnt_frames, cnt_bytes, cnt_seq_err); end
    n_tests++; if (cnt_runt !== 32'd0 || cnt_ctrl_err !== 32'd0) begin n_fail++; $display("FAIL clr_errs: got %0d/%0d want 0/0", cnt_runt, cnt_ctrl_err); end
    n_tests++; if (lat_min !== 32'hFFFF_FFFF || lat_max !== 32'd0) begin n_fail++; $display("FAIL clr_lat: got %0h/%0h want ffffffff/0", lat_min, lat_max); end
    preamble();
    put(8'h00, 64'h0);
    put(8'h00, 64'h0);
    sys_rst_n = 1'b0;
    put(8'h00, 64'h0);
    put(8'h00, 64'h0);
    sys_rst_n = 1'b1;
    put(8'h00, 64'h0);
    idle(); idle(); idle(); idle();
    n_tests++; if (cnt_frames !== 32'd0 || cnt_runt !== 32'd0 || cnt_ctrl_err !== 32'd0) begin n_fail++; $display("FAIL rst_mid: got %0d/%0d/%0d want 0/0/0", cnt_frames, cnt_runt, cnt_ctrl_err); end
    n_tests++; if (lat_min !== 32'hFFFF_FFFF || frame_seq !== 32'd0) begin n_fail++; $display("FAIL rst_vals: got %0h/%0d want ffffffff/0", lat_min, frame_seq); end
    send_frame(64, 32'd777, 500);
    idle(); idle(); idle();
    n_tests++; if (cnt_frames !== 32'd1 || cnt_seq_err !== 32'd0 || frame_seq !== 32'd777) begin n_fail++; $display("FAIL post_rst: got %0d/%0d/%0d want 1/0/777", cnt_frames, cnt_seq_err, frame_seq); end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    stat_clr  = 1'b0;
    ts_now    = 64'h1000;
    xgmii_rxc = 8'hFF;
    xgmii_rxd = {8{XGMII_IDLE}};
    idle(); idle();
    sys_rst_n = 1'b1;
    idle(); idle();
    test_reset();
    test_back_to_back();
    test_done_timing();
    test_term_lanes();
    test_seq_gap();
    test_errors();
    test_neg_latency();
    test_clr_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
